uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequencing/config controller sitting between the host and the UART receiver datapath.
//  Holds the active prescaler/parity config and drives it to the receiver.
//  Applies host config changes only between frames, never mid-frame.
//  Buffers received bytes in a small FIFO with a valid/ready consumer port; flags overrun, counts errors.
// PARAMETERS
//  DATA_WIDTH   8   receiver data width
//  SCALE_WIDTH  6   prescaler width
//  FIFO_DEPTH   4   byte buffer depth; power of 2, >=2
//  CNT_WIDTH    8   error counter width
//  DEF_PRESCALE 8   prescaler value loaded at reset
// PORTS
//  clk            in   1            single clock
//  reset_n        in   1            asynchronous reset, active-low
//  cfg_wr         in   1            1-cycle request to load cfg_* fields
//  cfg_prescaler  in   SCALE_WIDTH  requested prescaler
//  cfg_par_en     in   1            requested parity enable
//  cfg_par_typ    in   1            requested parity type (0 even, 1 odd)
//  cfg_ack        out  1            1-cycle pulse when the pending config becomes active
//  prescaler      out  SCALE_WIDTH  active prescaler to receiver
//  PAR_EN         out  1            active parity enable to receiver
//  PAR_TYP        out  1            active parity type to receiver
//  rx_line        in   1            serial line, same net as receiver RX_IN
//  rx_data_valid  in   1            receiver byte-done pulse
//  rx_p_data      in   DATA_WIDTH   receiver parallel data
//  rx_stop_err    in   1            receiver stop error
//  rx_par_err     in   1            receiver parity error
//  m_data         out  DATA_WIDTH   FIFO head
//  m_valid        out  1            FIFO not empty
//  m_ready        in   1            consumer accept; pop when m_valid & m_ready
//  overrun        out  1            sticky: byte dropped on full FIFO
//  clr_stats      in   1            clears overrun and error counters
//  stop_err_cnt   out  CNT_WIDTH    stop-error count, saturating
//  par_err_cnt    out  CNT_WIDTH    parity-error count, saturating
// BEHAVIOUR
//  Reset: prescaler=DEF_PRESCALE, PAR_EN=0, PAR_TYP=0, FIFO empty, m_valid=0, m_data=0,
//   cfg_ack=0, overrun=0, counters=0, pending cleared, FSM=IDLE. Reset mid-frame discards everything.
//  rx_line passes a 2-flop synchronizer (line_s); synchronizer resets to 1.
//  cfg_wr captures cfg_* into a pending register and sets pending; a later cfg_wr overwrites it.
//  FSM:
//   IDLE : line_s==0 -> FRAME (load timeout = 12*prescaler cycles, width SCALE_WIDTH+4);
//          else if pending -> APPLY.
//          line_s==0 and pending in the same cycle: FRAME wins, pending is kept.
//   FRAME: rx_data_valid|rx_stop_err|rx_par_err -> WAIT_HI; timeout reaching 0 -> WAIT_HI.
//   WAIT_HI: line_s==1 -> IDLE.
//   APPLY: copy pending to active outputs, clear pending, cfg_ack=1 for exactly this cycle -> IDLE.
//   cfg_wr in the same cycle as APPLY: the new value stays pending and is applied on a later visit.
//  FIFO push when rx_data_valid & !rx_stop_err & !rx_par_err (any state).
//  Latency: pushed byte visible on m_data with m_valid=1 the next cycle.
//  Full FIFO: push with simultaneous pop -> both occur. Push without pop -> byte dropped, overrun<=1.
//  Empty FIFO: pop is ignored. Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
//  overrun set has priority over clr_stats in the same cycle.
// CONFIGURATION
//  UART_RX_CTRL_STATS_EN defined: stop_err_cnt/par_err_cnt count +1 per cycle their input is high.
//   They saturate at all-ones. clr_stats zeroes them; an increment in the same cycle is lost.
//  Undefined: both counters are constant 0; clr_stats still clears overrun.
// TESTING
//  T1 reset, then cfg_wr{prescaler=16,par_en=1,typ=1} with line idle -> cfg_ack 3 cycles later; outputs updated.
//  T2 start bit low, then cfg_wr mid-frame -> no cfg_ack until rx_data_valid and line high.
//   Then one cfg_ack; prescaler is unchanged during the frame.
//  T3 push 0xA5,0x3C with m_ready=0 -> m_valid=1, m_data=0xA5; m_ready=1 for 2 cycles -> 0x3C, then m_valid=0.
//  T4 push 5 bytes into depth-4 with m_ready=0 -> byte 5 dropped, overrun=1; pop order 1..4.
//   clr_stats -> overrun=0.
//  T5 rx_data_valid with rx_par_err -> no push; par_err_cnt=1 (STATS_EN) or 0 (no macro).
//   300 par_err pulses -> 255.
//  T6 line low with no receiver response -> FRAME exits after 12*prescaler cycles.
//   Then WAIT_HI, then IDLE once line high; pending cfg is then applied.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver config sequencer with frame-safe config apply and receive byte FIFO
// Optional saturating error counters are built when UART_RX_CTRL_STATS_EN is defined.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int SCALE_WIDTH  = 6,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_WIDTH    = 8,
   parameter int DEF_PRESCALE = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cfg_wr,
   input  logic [SCALE_WIDTH-1:0] cfg_prescaler,
   input  logic                   cfg_par_en,
   input  logic                   cfg_par_typ,
   output logic                   cfg_ack,
   output logic [SCALE_WIDTH-1:0] prescaler,
   output logic                   PAR_EN,
   output logic                   PAR_TYP,
   input  logic                   rx_line,
   input  logic                   rx_data_valid,
   input  logic [DATA_WIDTH-1:0]  rx_p_data,
   input  logic                   rx_stop_err,
   input  logic                   rx_par_err,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   overrun,
   input  logic                   clr_stats,
   output logic [CNT_WIDTH-1:0]   stop_err_cnt,
   output logic [CNT_WIDTH-1:0]   par_err_cnt
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int TMR_W = SCALE_WIDTH + 4;

   typedef enum logic [1:0] {IDLE, FRAME, WAIT_HI, APPLY} state_t;

   state_t                 state, state_nxt;
   logic [TMR_W-1:0]       timer, timer_nxt;
   logic                   line_meta, line_s;
   logic                   pending;
   logic [SCALE_WIDTH-1:0] pend_prescaler;
   logic                   pend_par_en, pend_par_typ;

   logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [PTR_W:0]         count;
   logic                   push_req, push, pop, full;

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      case (state)
         IDLE: begin
            if (!line_s) begin
               state_nxt = FRAME;
               timer_nxt = TMR_W'(prescaler) * TMR_W'(12);
            end else if (pending) begin
               state_nxt = APPLY;
            end
         end
         FRAME: begin
            timer_nxt = timer - TMR_W'(1);
            // timer<=1 means this is the last counted cycle (also covers prescaler 0)
            if (rx_data_valid || rx_stop_err || rx_par_err || timer <= TMR_W'(1))
               state_nxt = WAIT_HI;
         end
         WAIT_HI: if (line_s) state_nxt = IDLE;
         APPLY:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         timer     <= '0;
         line_meta <= 1'b1;
         line_s    <= 1'b1;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         line_meta <= rx_line;
         line_s    <= line_meta;
      end
   end

   // A cfg_wr during APPLY wins over the clear, so it stays pending for a later visit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending        <= 1'b0;
         pend_prescaler <= '0;
         pend_par_en    <= 1'b0;
         pend_par_typ   <= 1'b0;
         prescaler      <= SCALE_WIDTH'(DEF_PRESCALE);
         PAR_EN         <= 1'b0;
         PAR_TYP        <= 1'b0;
         cfg_ack        <= 1'b0;
      end else begin
         cfg_ack <= (state == APPLY);
         if (state == APPLY) begin
            prescaler <= pend_prescaler;
            PAR_EN    <= pend_par_en;
            PAR_TYP   <= pend_par_typ;
         end
         if (cfg_wr) begin
            pending        <= 1'b1;
            pend_prescaler <= cfg_prescaler;
            pend_par_en    <= cfg_par_en;
            pend_par_typ   <= cfg_par_typ;
         end else if (state == APPLY) begin
            pending <= 1'b0;
         end
      end
   end

   assign push_req = rx_data_valid & ~rx_stop_err & ~rx_par_err;
   assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign m_valid  = (count != '0);
   assign pop      = m_valid & m_ready;
   assign push     = push_req & (~full | pop);
   assign m_data   = m_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx_p_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
         if (push_req && full && !pop) overrun <= 1'b1;
         else if (clr_stats)           overrun <= 1'b0;
      end
   end

`ifdef UART_RX_CTRL_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stop_err_cnt <= '0;
         par_err_cnt  <= '0;
      end else if (clr_stats) begin
         stop_err_cnt <= '0;
         par_err_cnt  <= '0;
      end else begin
         if (rx_stop_err && stop_err_cnt != '1) stop_err_cnt <= stop_err_cnt + CNT_WIDTH'(1);
         if (rx_par_err  && par_err_cnt  != '1) par_err_cnt  <= par_err_cnt  + CNT_WIDTH'(1);
      end
   end
`else
   assign stop_err_cnt = '0;
   assign par_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
   logic       clk = 1'b0;
   logic       reset_n;
   logic       cfg_wr;
   logic [5:0] cfg_prescaler;
   logic       cfg_par_en, cfg_par_typ;
   logic       cfg_ack;
   logic [5:0] prescaler;
   logic       PAR_EN, PAR_TYP;
   logic       rx_line, rx_data_valid, rx_stop_err, rx_par_err;
   logic [7:0] rx_p_data;
   logic [7:0] m_data;
   logic       m_valid, m_ready;
   logic       overrun, clr_stats;
   logic [7:0] stop_err_cnt, par_err_cnt;

   int checks = 0;
   int failures = 0;
   int n;
   logic ack_seen;

`ifdef UART_RX_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   uart_rx_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_wr(cfg_wr), .cfg_prescaler(cfg_prescaler), .cfg_par_en(cfg_par_en),
      .cfg_par_typ(cfg_par_typ), .cfg_ack(cfg_ack),
      .prescaler(prescaler), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .rx_line(rx_line), .rx_data_valid(rx_data_valid), .rx_p_data(rx_p_data),
      .rx_stop_err(rx_stop_err), .rx_par_err(rx_par_err),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .overrun(overrun), .clr_stats(clr_stats),
      .stop_err_cnt(stop_err_cnt), .par_err_cnt(par_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; cfg_wr = 1'b0; cfg_prescaler = '0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
      rx_line = 1'b1; rx_data_valid = 1'b0; rx_p_data = '0; rx_stop_err = 1'b0; rx_par_err = 1'b0;
      m_ready = 1'b0; clr_stats = 1'b0;
      repeat (3) tick();
      check("rst_prescaler", 32'(prescaler), 8);
      check("rst_par_en", 32'(PAR_EN), 0);
      check("rst_par_typ", 32'(PAR_TYP), 0);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_cfg_ack", 32'(cfg_ack), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_cnts", {16'h0, stop_err_cnt, par_err_cnt}, 0);
      reset_n = 1'b1;
      tick();

      // T1: config applied from idle
      cfg_prescaler = 6'd16; cfg_par_en = 1'b1; cfg_par_typ = 1'b1; cfg_wr = 1'b1;
      tick();
      cfg_wr = 1'b0;
      check("t1_ack_c1", 32'(cfg_ack), 0);
      tick();
      check("t1_ack_c2", 32'(cfg_ack), 0);
      tick();
      check("t1_ack_c3", 32'(cfg_ack), 1);
      check("t1_prescaler", 32'(prescaler), 16);
      check("t1_par_en", 32'(PAR_EN), 1);
      check("t1_par_typ", 32'(PAR_TYP), 1);
      tick();
      check("t1_ack_pulse", 32'(cfg_ack), 0);

      // T2: config request held off during a frame
      rx_line = 1'b0;
      repeat (4) tick();
      cfg_prescaler = 6'd2; cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_wr = 1'b1;
      tick();
      cfg_wr = 1'b0;
      ack_seen = 1'b0;
      repeat (8) begin tick(); ack_seen |= cfg_ack; end
      check("t2_no_ack_frame", 32'(ack_seen), 0);
      check("t2_prescaler_hold", 32'(prescaler), 16);
      rx_data_valid = 1'b1; rx_p_data = 8'h11;
      tick();
      rx_data_valid = 1'b0;
      check("t2_push_valid", 32'(m_valid), 1);
      check("t2_push_data", 32'(m_data), 32'h11);
      repeat (4) begin tick(); ack_seen |= cfg_ack; end
      check("t2_no_ack_line_low", 32'(ack_seen), 0);
      rx_line = 1'b1;
      n = 0;
      while (!cfg_ack && n < 20) begin tick(); n++; end
      check("t2_ack_latency", 32'(n), 5);
      check("t2_prescaler_new", 32'(prescaler), 2);
      check("t2_par_en_new", 32'(PAR_EN), 0);
      tick();
      check("t2_ack_once", 32'(cfg_ack), 0);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("t2_drained", 32'(m_valid), 0);

      // T3: FIFO order and one-cycle latency
      rx_data_valid = 1'b1; rx_p_data = 8'hA5;
      tick();
      check("t3_first_valid", 32'(m_valid), 1);
      check("t3_first_data", 32'(m_data), 32'hA5);
      rx_p_data = 8'h3C;
      tick();
      rx_data_valid = 1'b0;
      check("t3_head_a5", 32'(m_data), 32'hA5);
      m_ready = 1'b1;
      tick();
      check("t3_head_3c", 32'(m_data), 32'h3C);
      check("t3_valid_3c", 32'(m_valid), 1);
      tick();
      check("t3_empty", 32'(m_valid), 0);
      check("t3_empty_data", 32'(m_data), 0);
      tick();
      check("t3_empty_pop_ignored", 32'(m_valid), 0);
      m_ready = 1'b0;

      // T4: overrun on full, priority over clr_stats, then full push with pop
      for (int i = 1; i <= 4; i++) begin
         rx_data_valid = 1'b1; rx_p_data = 8'(i);
         tick();
      end
      rx_p_data = 8'd5; clr_stats = 1'b1;
      tick();
      rx_data_valid = 1'b0; clr_stats = 1'b0;
      check("t4_overrun_set", 32'(overrun), 1);
      m_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("t4_pop_%0d", i), 32'(m_data), 32'(i));
         tick();
      end
      check("t4_empty", 32'(m_valid), 0);
      m_ready = 1'b0;
      check("t4_overrun_sticky", 32'(overrun), 1);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check("t4_overrun_clr", 32'(overrun), 0);
      for (int i = 0; i < 4; i++) begin
         rx_data_valid = 1'b1; rx_p_data = 8'(8'h10 + i);
         tick();
      end
      rx_p_data = 8'h14; m_ready = 1'b1;
      tick();
      rx_data_valid = 1'b0;
      check("t4_full_pushpop_ovr", 32'(overrun), 0);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("t4_pp_pop_%0d", i), 32'(m_data), 32'(8'h10 + i));
         tick();
      end
      check("t4_pp_empty", 32'(m_valid), 0);
      m_ready = 1'b0;

      // T5: errored bytes are not pushed; counters saturate and clear
      rx_data_valid = 1'b1; rx_par_err = 1'b1; rx_p_data = 8'h77;
      tick();
      rx_data_valid = 1'b0; rx_par_err = 1'b0;
      check("t5_no_push", 32'(m_valid), 0);
      check("t5_par_cnt_1", 32'(par_err_cnt), STATS ? 1 : 0);
      rx_par_err = 1'b1;
      repeat (300) tick();
      rx_par_err = 1'b0;
      check("t5_par_cnt_sat", 32'(par_err_cnt), STATS ? 255 : 0);
      rx_stop_err = 1'b1;
      repeat (3) tick();
      rx_stop_err = 1'b0;
      check("t5_stop_cnt", 32'(stop_err_cnt), STATS ? 3 : 0);
      clr_stats = 1'b1; rx_par_err = 1'b1;
      tick();
      clr_stats = 1'b0; rx_par_err = 1'b0;
      check("t5_par_cnt_clr", 32'(par_err_cnt), 0);
      check("t5_stop_cnt_clr", 32'(stop_err_cnt), 0);

      // T6: frame timeout with no receiver response, prescaler 2 -> 24 frame cycles
      rx_line = 1'b0;
      tick();
      rx_line = 1'b1;
      n = 1;
      tick(); n++;
      tick(); n++;
      cfg_prescaler = 6'd7; cfg_par_en = 1'b1; cfg_par_typ = 1'b0; cfg_wr = 1'b1;
      tick(); n++;
      cfg_wr = 1'b0;
      check("t6_no_early_ack", 32'(cfg_ack), 0);
      while (!cfg_ack && n < 200) begin tick(); n++; end
      check("t6_timeout_ack_cycle", 32'(n), 30);
      check("t6_prescaler", 32'(prescaler), 7);
      check("t6_par_en", 32'(PAR_EN), 1);
      check("t6_par_typ", 32'(PAR_TYP), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
